mul_share_arbiter: RTL and testbench

//  Shares one saturating pixel multiplier (Rs*Rm, clamped to SAT_MAX) between

---
 rtl/mul_share_arbiter.sv | 134 +++++++++++++
 tb/tb_mul_share_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin shared saturating multiplier with 2-stage result path
module mul_share_arbiter #(
  parameter int N       = 32,
  parameter int NREQ    = 2,
  parameter int SAT_MAX = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*N-1:0]         req_rs,
  input  logic [NREQ*N-1:0]         req_rm,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [N-1:0]              rsp_result,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = IW + 1;
  localparam int PW = 2 * N;
  localparam logic [PW-1:0] SAT_WIDE   = PW'(SAT_MAX);
  localparam logic [N-1:0]  SAT_NARROW = N'(SAT_MAX);

  // Round-robin pointer: first requester to consider on the next contest
  logic [IW-1:0] rr_ptr;

  // Stage 1: captured operands of the accepted request
  logic          s1_valid;
  logic [IW-1:0] s1_id;
  logic [N-1:0]  s1_rs;
  logic [N-1:0]  s1_rm;

  // Per-requester operand views of the flat buses
  logic [N-1:0]  rs_arr [NREQ];
  logic [N-1:0]  rm_arr [NREQ];

  // Grant scan results
  logic          gnt_found;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] ptr_next;
  logic [SW-1:0] scan_sum;
  logic [IW-1:0] scan_idx;

  // Full-width product so an N-bit wrap cannot slip under the clamp
  logic [PW-1:0] prod;
  logic [N-1:0]  sat_val;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign rs_arr[gi] = req_rs[gi*N +: N];
      assign rm_arr[gi] = req_rm[gi*N +: N];
    end
  endgenerate

  // Scan requesters from rr_ptr upward (wrapping) and grant the first valid one
  always_comb begin
    req_ready = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (!rst && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_sum = {1'b0, rr_ptr} + SW'(k);
        if (scan_sum >= SW'(NREQ)) begin
          scan_sum = scan_sum - SW'(NREQ);
        end
        scan_idx = scan_sum[IW-1:0];
        if (!gnt_found && req_valid[scan_idx]) begin
          gnt_found = 1'b1;
          gnt_id    = scan_idx;
        end
      end
      if (gnt_found) begin
        req_ready[gnt_id] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner so it goes to the back of the line
  always_comb begin
    ptr_next = rr_ptr;
    if (gnt_found) begin
      if (gnt_id == IW'(NREQ - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = gnt_id + 1'b1;
      end
    end
  end

  assign prod    = {{N{1'b0}}, s1_rs} * {{N{1'b0}}, s1_rm};
  assign sat_val = (prod > SAT_WIDE) ? SAT_NARROW : prod[N-1:0];

  // Stage 1 capture and round-robin pointer update; stall freezes both
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_rs    <= '0;
      s1_rm    <= '0;
    end else if (!stall) begin
      s1_valid <= gnt_found;
      rr_ptr   <= ptr_next;
      if (gnt_found) begin
        s1_id <= gnt_id;
        s1_rs <= rs_arr[gnt_id];
        s1_rm <= rm_arr[gnt_id];
      end
    end
  end

  // Stage 2: register the saturated product; result holds when nothing new arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else if (!stall) begin
      rsp_valid <= s1_valid;
      rsp_id    <= s1_id;
      if (s1_valid) begin
        rsp_result <= sat_val;
      end
    end
  end

  assign busy = s1_valid | rsp_valid;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - randomized self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                stall;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*N-1:0]   req_rs;
  logic [NREQ*N-1:0]   req_rm;
  logic                rsp_valid;
  logic [0:0]          rsp_id;
  logic [N-1:0]        rsp_result;
  logic                busy;

  always #5 clk = ~clk;

  mul_share_arbiter #(.N(N), .NREQ(NREQ), .SAT_MAX(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs     (req_rs),
    .req_rm     (req_rm),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: next requester to favour, pending op, visible response
  int          m_next = 0;
  bit          p_v    = 1'b0;
  int          p_id   = 0;
  logic [31:0] p_res  = '0;
  bit          r_v    = 1'b0;
  int          r_id   = 0;
  logic [31:0] r_res  = '0;
  int          last_g = -1;
  logic [NREQ-1:0] seen_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] ref_sat(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = 64'(a) * 64'(b);
    if (p > 64'd255) return 32'd255;
    return p[31:0];
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v, input bit r, input bit st);
    int idx;
    if (r || st) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_next + k) % NREQ;
      if (((v >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  // One clock: drive inputs after a falling edge, check grant, model the edge, check outputs
  task automatic cycle(input bit r, input bit st, input logic [NREQ-1:0] v,
                       input logic [31:0] rs0, input logic [31:0] rm0,
                       input logic [31:0] rs1, input logic [31:0] rm1);
    int g;
    logic [NREQ-1:0] er;
    rst       = r;
    stall     = st;
    req_valid = v;
    req_rs    = {rs1, rs0};
    req_rm    = {rm1, rm0};
    #1;
    g  = model_grant(v, r, st);
    er = '0;
    if (g >= 0) er = NREQ'(1) << g;
    seen_ready = req_ready;
    check("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    if (r) begin
      m_next = 0; p_v = 1'b0; p_id = 0; p_res = '0;
      r_v = 1'b0; r_id = 0; r_res = '0;
    end else if (!st) begin
      r_v = p_v;
      if (p_v) begin
        r_id  = p_id;
        r_res = p_res;
      end
      p_v = (g >= 0);
      if (g >= 0) begin
        p_id   = g;
        p_res  = (g == 0) ? ref_sat(rs0, rm0) : ref_sat(rs1, rm1);
        m_next = (g + 1) % NREQ;
      end
    end
    last_g = g;
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(r_v));
    check("busy", 64'(busy), 64'(p_v | r_v));
    check("rsp_result", 64'(rsp_result), 64'(r_res));
    if (r_v) check("rsp_id", 64'(rsp_id), 64'(r_id));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
  endtask

  // Single op from requester 0, then read the result one cycle later
  task automatic single_op(input logic [31:0] rs, input logic [31:0] rm, input logic [31:0] exp);
    cycle(1'b0, 1'b0, 2'b01, rs, rm, 0, 0);
    cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
    check("single_valid", 64'(rsp_valid), 64'd1);
    check("single_result", 64'(rsp_result), 64'(exp));
    check("single_id", 64'(rsp_id), 64'd0);
    cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
    check("single_done", 64'(rsp_valid), 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 20));
      1: return 32'($urandom_range(0, 300));
      2: return $urandom;
      default: return 32'd1 << $urandom_range(0, 31);
    endcase
  endfunction

  bit          cv  [2];
  logic [31:0] crs [2];
  logic [31:0] crm [2];
  bit          last_rst;

  initial begin
    rst = 1'b1; stall = 1'b0; req_valid = '0; req_rs = '0; req_rm = '0;
    @(negedge clk);

    // Reset with every requester asking
    cycle(1'b1, 1'b0, 2'b11, 1, 1, 1, 1);
    check("reset_ready", 64'(seen_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_result", 64'(rsp_result), 64'd0);

    // Plain and saturating products
    single_op(32'd3, 32'd5, 32'd15);
    single_op(32'd16, 32'd16, 32'd255);
    single_op(32'h0001_0000, 32'h0001_0000, 32'd255);
    single_op(32'd15, 32'd17, 32'd255);
    single_op(32'd0, 32'hFFFF_FFFF, 32'd0);
    single_op(32'd1, 32'd255, 32'd255);

    // Round-robin alternation from a fresh pointer
    cycle(1'b1, 1'b0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 2'b11, 32'(i + 2), 32'd3, 32'(i + 10), 32'd2);
      check("rr_grant", 64'(seen_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i > 0) begin
        check("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rr_rsp_id", 64'((i - 1) % 2), 64'(rsp_id));
      end
    end
    cycle(1'b0, 1'b0, 2'b10, 0, 0, 32'd4, 32'd4);
    check("rr_regrant", 64'(seen_ready), 64'd2);
    idle(3);

    // Stall with ops in both stages
    cycle(1'b0, 1'b0, 2'b11, 32'd6, 32'd7, 32'd9, 32'd9);
    cycle(1'b0, 1'b0, 2'b11, 32'd6, 32'd7, 32'd9, 32'd9);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 2'b11, 32'd6, 32'd7, 32'd9, 32'd9);
      check("stall_ready", 64'(seen_ready), 64'd0);
      check("stall_hold_valid", 64'(rsp_valid), 64'd1);
      check("stall_hold_result", 64'(rsp_result), 64'd42);
    end
    cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
    check("stall_release_result", 64'(rsp_result), 64'd81);
    check("stall_release_id", 64'(rsp_id), 64'd1);
    cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
    check("stall_once", 64'(rsp_valid), 64'd0);

    // Reset while two ops are in flight
    cycle(1'b0, 1'b0, 2'b11, 32'd2, 32'd2, 32'd3, 32'd3);
    cycle(1'b0, 1'b0, 2'b11, 32'd2, 32'd2, 32'd3, 32'd3);
    cycle(1'b1, 1'b0, 2'b11, 32'd2, 32'd2, 32'd3, 32'd3);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
      check("midreset_no_rsp", 64'(rsp_valid), 64'd0);
    end
    cycle(1'b0, 1'b0, 2'b11, 32'd5, 32'd5, 32'd6, 32'd6);
    check("midreset_req0_first", 64'(seen_ready), 64'd1);
    idle(3);

    // Randomized traffic with stalls and occasional resets
    for (int i = 0; i < 2; i++) begin
      cv[i] = 1'b0; crs[i] = '0; crm[i] = '0;
    end
    last_rst = 1'b0;
    for (int c = 0; c < 500; c++) begin
      bit r;
      bit st;
      r  = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!cv[i] || last_g == i || last_rst) begin
          cv[i]  = ($urandom_range(0, 2) != 0);
          crs[i] = rnd_op();
          crm[i] = rnd_op();
        end
      end
      cycle(r, st, {cv[1], cv[0]}, crs[0], crm[0], crs[1], crm[1]);
      last_rst = r;
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
